// File: rtl/store_buffer.sv
// Store buffer between the M stage and a slow handshaked data RAM.
// Stores are queued and drained in order; loads wait on matching stores.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_byteen,
    input  logic             cpu_rd,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [PTR_W:0]   sb_count
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t state_q, state_d;

    logic [29:0] ent_addr [DEPTH];
    logic [31:0] ent_data [DEPTH];
    logic [3:0]  ent_be   [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;

    logic        is_store, is_load, full, push, pop, conflict;
    logic [PTR_W-1:0] offs;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  be_d;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign is_store = |cpu_byteen;
    assign is_load  = cpu_rd & ~is_store;
    assign full     = (count_q == CNT_FULL);
    assign push     = is_store & ~full;
    assign pop      = (state_q == WRITE) & mem_ack;
    assign sb_count = count_q;

    // An entry is live when its distance from head is below count.
    always_comb begin
        conflict = 1'b0;
        offs     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head_q;
            if (({1'b0, offs} < count_q) &&
                (ent_addr[i] == cpu_addr[31:2]))
                conflict = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        be_d      = mem_byteen;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        unique case (state_q)
            IDLE: begin
                cpu_stall = is_load;
                if (is_load && !conflict) begin
                    state_d = READ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    wdata_d = '0;
                    be_d    = '0;
                end else if (count_q != '0) begin
                    state_d = WRITE;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {ent_addr[head_q], 2'b00};
                    wdata_d = ent_data[head_q];
                    be_d    = ent_be[head_q];
                end
            end
            WRITE: begin
                cpu_stall = is_load;
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                end
            end
            READ: begin
                cpu_stall = is_load & ~mem_ack;
                if (mem_ack) begin
                    cpu_rdata = mem_rdata;
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    addr_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Full check sees count before any same-cycle pop.
        if (is_store && full)
            cpu_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byteen <= '0;
        end else begin
            state_q    <= state_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_byteen <= be_d;
            if (push)
                tail_q <= tail_q + PTR_ONE;
            if (pop)
                head_q <= head_q + PTR_ONE;
            if (push && !pop)
                count_q <= count_q + CNT_ONE;
            else if (pop && !push)
                count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            ent_addr[tail_q] <= cpu_addr[31:2];
            ent_data[tail_q] <= cpu_wdata;
            ent_be[tail_q]   <= cpu_byteen;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a RAM model and write/read scoreboards.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_rd, cpu_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;
    logic [2:0]  sb_count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteen(cpu_byteen), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .sb_count(sb_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] ram [256];

    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    bit   ack_hold = 0;
    logic stall_s, ack_s;
    logic [31:0] rdata_s;
    int   lat;
    int   n;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM model: ack after ack_delay cycles of a held request.
    task automatic start_cycle();
        mem_ack = 1'b0;
        if (!mem_req) begin
            wait_cnt = 0;
        end else if (!ack_hold) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
        mem_rdata = (mem_ack && !mem_we) ? ram[mem_addr[9:2]] : 32'h0;
    endtask

    task automatic end_cycle();
        wr_t e;
        logic [31:0] ra;
        #1;
        stall_s = cpu_stall;
        ack_s   = mem_ack;
        rdata_s = cpu_rdata;
        if (reset && mem_req && mem_ack) begin
            if (mem_we) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'h1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check("wr_addr", mem_addr, e.a);
                    check("wr_data", mem_wdata, e.d);
                    check("wr_be", 32'(mem_byteen), 32'(e.be));
                    for (int b = 0; b < 4; b++)
                        if (mem_byteen[b])
                            ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end else begin
                check("rd_expected", 32'(rd_q.size() != 0), 32'h1);
                if (rd_q.size() != 0) begin
                    ra = rd_q.pop_front();
                    check("rd_addr", mem_addr, ra);
                    check("rd_be", 32'(mem_byteen), 32'h0);
                end
            end
        end
        if (reset && cpu_byteen != 4'h0 && !cpu_stall)
            wr_q.push_back('{{cpu_addr[31:2], 2'b00}, cpu_wdata, cpu_byteen});
        @(posedge clk);
        #1;
        start_cycle();
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic rd);
        cpu_addr   = a;
        cpu_wdata  = d;
        cpu_byteen = be;
        cpu_rd     = rd;
        end_cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (sb_count == 3'd0 && !mem_req)
                break;
            cyc(32'h0, 32'h0, 4'h0, 1'b0);
        end
        check("drain_count", 32'(sb_count), 32'h0);
        check("drain_req", 32'(mem_req), 32'h0);
        check("drain_wr_q", 32'(wr_q.size()), 32'h0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp,
                           output int l);
        bit done;
        rd_q.push_back({a[31:2], 2'b00});
        l    = 0;
        done = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(a, 32'h0, 4'h0, 1'b1);
            l++;
            if (!stall_s) begin
                done = 1;
                break;
            end
            if (l == 1)
                check("ld_rdata_stalled", rdata_s, 32'h0);
        end
        check("ld_done", 32'(done), 32'h1);
        check("ld_rdata", rdata_s, exp);
        check("ld_ack_cycle", 32'(ack_s), 32'h1);
    endtask

    initial begin
        reset      = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_byteen = '0;
        cpu_rd     = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 256; i++)
            ram[i] = 32'h0;
        ram[32] = 32'h5A5A1234;
        ram[33] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_be", 32'(mem_byteen), 32'h0);
        check("rst_count", 32'(sb_count), 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        reset = 1'b1;
        start_cycle();

        // back-to-back word stores, slow RAM
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            cyc(32'(4 * i), 32'(32'h11 * (i + 1)), 4'hF, 1'b0);
            check("t1_nostall", 32'(stall_s), 32'h0);
        end
        check("t1_count4", 32'(sb_count), 32'h4);
        drain();

        // full buffer stalls a fifth store until a slot frees
        ack_hold  = 1;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0);
            check("t2_fill_nostall", 32'(stall_s), 32'h0);
        end
        check("t2_count4", 32'(sb_count), 32'h4);
        check("t2_head_req", 32'(mem_req), 32'h1);
        check("t2_head_we", 32'(mem_we), 32'h1);
        check("t2_head_addr", mem_addr, 32'h100);
        cyc(32'h10, 32'hABABABAB, 4'b0001, 1'b0);
        check("t2_full_stall", 32'(stall_s), 32'h1);
        cyc(32'h10, 32'hABABABAB, 4'b0001, 1'b0);
        check("t2_full_stall2", 32'(stall_s), 32'h1);
        ack_hold = 0;
        cyc(32'h10, 32'hABABABAB, 4'b0001, 1'b0);
        check("t2_full_stall3", 32'(stall_s), 32'h1);
        cyc(32'h10, 32'hABABABAB, 4'b0001, 1'b0);
        check("t2_pop_cycle_ack", 32'(ack_s), 32'h1);
        check("t2_pop_cycle_stall", 32'(stall_s), 32'h1);
        cyc(32'h10, 32'hABABABAB, 4'b0001, 1'b0);
        check("t2_enq_nostall", 32'(stall_s), 32'h0);
        check("t2_count_refill", 32'(sb_count), 32'h4);
        drain();

        // load hits pending store: waits for drain, then reads new data
        ack_delay = 2;
        cyc(32'h20, 32'hDEADBEEF, 4'hF, 1'b0);
        do_load(32'h22, 32'hDEADBEEF, lat);
        check("t3_latency", 32'(lat), 32'd8);
        check("t3_count", 32'(sb_count), 32'h0);
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        check("t3_rdata_idle", rdata_s, 32'h0);

        // load takes priority over draining
        ack_delay = 1;
        cyc(32'h40, 32'h12345678, 4'hF, 1'b0);
        do_load(32'h80, 32'h5A5A1234, lat);
        check("t4_latency", 32'(lat), 32'd3);
        check("t4_no_drain", 32'(sb_count), 32'h1);
        ack_delay = 0;
        do_load(32'h84, 32'h0BADF00D, lat);
        check("t4_min_latency", 32'(lat), 32'd2);
        check("t4_no_drain2", 32'(sb_count), 32'h1);
        drain();

        // reset in the middle of a write, then a stray ack
        ack_delay = 10;
        for (int i = 0; i < 3; i++)
            cyc(32'h60 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 1'b0);
        check("t5_count3", 32'(sb_count), 32'h3);
        check("t5_writing", 32'(mem_req & mem_we), 32'h1);
        reset = 1'b0;
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        wr_q.delete();
        check("t5_rst_req", 32'(mem_req), 32'h0);
        check("t5_rst_count", 32'(sb_count), 32'h0);
        mem_ack = 1'b1;
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        check("t5_late_ack_count", 32'(sb_count), 32'h0);
        check("t5_late_ack_req", 32'(mem_req), 32'h0);
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        check("t5_stays_idle", 32'(mem_req), 32'h0);
        check("t5_stays_empty", 32'(sb_count), 32'h0);

        // simultaneous push and pop at count 2, pointers wrap twice
        ack_hold  = 1;
        ack_delay = 0;
        cyc(32'h200, 32'h600, 4'hF, 1'b0);
        cyc(32'h204, 32'h601, 4'hF, 1'b0);
        check("t6_count2", 32'(sb_count), 32'h2);
        ack_hold = 0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            if (n >= 8)
                break;
            if (mem_ack) begin
                cyc(32'h208 + 32'(4 * n), 32'h700 + 32'(n), 4'hF, 1'b0);
                check("t6_push_nostall", 32'(stall_s), 32'h0);
                check("t6_count_steady", 32'(sb_count), 32'h2);
                n++;
            end else begin
                cyc(32'h0, 32'h0, 4'h0, 1'b0);
            end
        end
        check("t6_pairs", 32'(n), 32'd8);
        drain();
        check("end_rd_q", 32'(rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
